// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
//   sa_state_t        : controller states (IDLE, RUN, DONE)
//   SA_DEFAULT_WIDTH  : default operand/result width
package serial_adder_pkg;

    typedef enum logic [1:0] {
        SA_IDLE = 2'd0,
        SA_RUN  = 2'd1,
        SA_DONE = 2'd2
    } sa_state_t;

    localparam int SA_DEFAULT_WIDTH = 64;

endpackage

// File: rtl/serial_adder_64_full_adder.sv
// One-bit full adder cell, the only arithmetic in the serial adder.
// Ports:
//   a, b  in   operand bits
//   ci    in   carry in
//   s     out  sum bit
//   co    out  carry out
module FullAdder1Bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_64.sv
// Bit-serial WIDTH-bit adder: one full-adder cell fed LSB first, one bit per
// clock, carry held in a flop. valid/ready handshake on both sides; one
// transaction takes WIDTH+2 cycles.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a `sub` input; when set at
// accept the block computes a-b (cout=1 means no borrow).
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands present on a/b/cin
//   in_ready   out  operands can be accepted (IDLE only)
//   a, b       in   WIDTH-bit operands
//   cin        in   carry into bit 0
//   sub        in   (SERIAL_ADDER_SUB_EN only) subtract instead of add
//   out_valid  out  sum/cout hold a completed result (DONE)
//   out_ready  in   consumer takes the result
//   sum        out  WIDTH-bit result
//   cout       out  carry out of bit WIDTH-1
//   busy       out  high in RUN or DONE
//
// state   | meaning
// SA_IDLE | waiting for operands, in_ready high
// SA_RUN  | one bit per cycle through the cell, cnt tracks bit index
// SA_DONE | result held on sum/cout until out_ready
module serial_adder_64
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sa_state_t        state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] b_load;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             carry_load;
    logic             cout_q;
    logic             do_sub;
    logic             fa_s;
    logic             fa_co;

`ifdef SERIAL_ADDER_SUB_EN
    assign do_sub = sub;
`else
    assign do_sub = 1'b0;
`endif

    // Subtraction is a + ~b + 1, so the forced carry replaces cin.
    assign b_load     = do_sub ? ~b : b;
    assign carry_load = do_sub ? 1'b1 : cin;

    FullAdder1Bit u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    generate
        if (WIDTH == 1) begin : g_one_bit
            assign sum_next = fa_s;
        end else begin : g_multi_bit
            assign sum_next = {fa_s, sum_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= SA_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                SA_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
                        state <= SA_RUN;
                    end
                end
                SA_RUN: begin
                    sum_sh <= sum_next;
                    carry  <= fa_co;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        // carry flop keeps the final Co too, but cout gets its
                        // own copy so it does not show cin while RUN restarts.
                        cout_q <= fa_co;
                        state  <= SA_DONE;
                    end
                end
                SA_DONE: begin
                    if (out_ready) begin
                        state <= SA_IDLE;
                    end
                end
                default: state <= SA_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == SA_IDLE);
    assign out_valid = (state == SA_DONE);
    assign busy      = (state != SA_IDLE);
    assign sum       = sum_sh;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder_64.sv
// Self-checking bench for serial_adder_64 (WIDTH=64). Expected results come
// from plain 65-bit arithmetic on the operands.
module tb_serial_adder_64;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    serial_adder_64 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    // Reference: a + b + cin, or a + ~b + 1 for subtraction, in 65 bits.
    function automatic logic [64:0] model(input logic [63:0] av, input logic [63:0] bv,
                                          input logic cv, input logic sv);
        logic [64:0] r;
        if (sv) r = {1'b0, av} + {1'b0, ~bv} + 65'd1;
        else    r = {1'b0, av} + {1'b0, bv} + {64'd0, cv};
        return r;
    endfunction

    // One full transaction. hold: cycles out_ready stays low once out_valid is
    // seen; intrude: offer a second operand pair during that wait.
    task automatic do_op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                         input logic cv, input logic sv, input int hold, input bit intrude);
        logic [64:0] exp;
        int n;
        exp = model(av, bv, cv, sv);
        n = 0;
        while (!in_ready && n < 200) begin
            edge_wait();
            n++;
        end
        check({tag, "_ready"}, in_ready, 1'b1);
        a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
        edge_wait();
        in_valid = 1'b0;
        // sampled only at accept
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom); sub = 1'($urandom);
        check({tag, "_busy"}, busy, 1'b1);
        n = 0;
        while (!out_valid && n < W + 10) begin
            edge_wait();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(W));
        check({tag, "_sum"}, sum, exp[63:0]);
        check({tag, "_cout"}, cout, exp[64]);
        if (intrude) begin
            a = 64'd2; b = 64'd2; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            edge_wait();
            check({tag, "_hold_sum"}, sum, exp[63:0]);
            check({tag, "_hold_in_ready"}, in_ready, 1'b0);
            check({tag, "_hold_valid"}, out_valid, 1'b1);
        end
        out_ready = 1'b1;
        edge_wait();
        out_ready = 1'b0;
        in_valid = 1'b0;
        check({tag, "_idle"}, in_ready, 1'b1);
        check({tag, "_valid_low"}, out_valid, 1'b0);
        if (intrude) begin
            edge_wait();
            check({tag, "_no_accept"}, busy, 1'b0);
        end
    endtask

    initial begin
        logic [63:0] ra, rb;
        int t0, t1, n;

        // reset state
        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sum", sum, 64'd0);
        check("rst_cout", cout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        edge_wait();

        do_op("t1_one", 64'd1, 64'd0, 1'b0, 1'b0, 0, 1'b0);
        do_op("t2_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b0);
        do_op("t3_hold", 64'd5, 64'd3, 1'b1, 1'b0, 10, 1'b1);
        check("t3_sum_after", sum, 64'd9);

        // reset during bit 30
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'b1; in_valid = 1'b1;
        edge_wait();
        in_valid = 1'b0;
        for (int i = 0; i < 30; i++) edge_wait();
        check("t4_mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t4_out_valid", out_valid, 1'b0);
        check("t4_sum", sum, 64'd0);
        check("t4_cout", cout, 1'b0);
        check("t4_in_ready", in_ready, 1'b1);
        check("t4_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        edge_wait();
        do_op("t4_next", 64'd7, 64'd8, 1'b0, 1'b0, 0, 1'b0);

        // back-to-back with out_ready and in_valid tied high
        out_ready = 1'b1;
        a = 64'd1; b = 64'd1; cin = 1'b0; in_valid = 1'b1;
        edge_wait();
        t0 = cyc;
        a = 64'd2; b = 64'd2;
        n = 0;
        while (!out_valid && n < W + 10) begin edge_wait(); n++; end
        check("t5_first_sum", sum, 64'd2);
        n = 0;
        while (!in_ready && n < 10) begin edge_wait(); n++; end
        edge_wait();
        t1 = cyc;
        check("t5_spacing", 64'(t1 - t0), 64'(W + 2));
        n = 0;
        while (!out_valid && n < W + 10) begin edge_wait(); n++; end
        in_valid = 1'b0;
        check("t5_second_sum", sum, 64'd4);
        check("t5_second_cout", cout, 1'b0);
        edge_wait();
        out_ready = 1'b0;
        edge_wait();
        check("t5_idle", busy, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        do_op("t6_sub_pos", 64'd10, 64'd3, 1'b0, 1'b1, 0, 1'b0);
        do_op("t6_sub_neg", 64'd3, 64'd10, 1'b1, 1'b1, 0, 1'b0);
`endif

        // random operands against the arithmetic model
        for (int i = 0; i < 8; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i == 0) rb = ~ra;
`ifdef SERIAL_ADDER_SUB_EN
            do_op("rand", ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
`else
            do_op("rand", ra, rb, 1'($urandom), 1'b0, int'($urandom_range(0, 3)), 1'b0);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
